// File: rtl/mfp_ahb_interconnect_pkg.sv
// mfp_ahb_interconnect_pkg
//   Shared constants for the MIPSfpga AHB-lite interconnect: HTRANS
//   encodings, default-slave FSM state encoding and the default
//   five-slave address map (boot RAM, program RAM, GPIO, segment, bot).
//   Slave i occupies bits [32i+31:32i] of the packed base/mask vectors.
package mfp_ahb_interconnect_pkg;

  localparam int MFP_N_SLAVES_DEF = 5;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  //                          bot           segment       gpio          prog RAM      boot RAM
  localparam logic [32*MFP_N_SLAVES_DEF-1:0] MFP_SLV_BASE_DEF =
    {32'h1F40_0000, 32'h1F70_0000, 32'h1F80_0000, 32'h0000_0000, 32'h1FC0_0000};
  localparam logic [32*MFP_N_SLAVES_DEF-1:0] MFP_SLV_MASK_DEF =
    {32'h1FFF_F000, 32'h1FFF_F000, 32'h1FFF_F000, 32'h1FF8_0000, 32'h1FC0_0000};

  // True for NONSEQ/SEQ, the only transfer types that carry a data phase.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/mfp_ahb_default_slave.sv
// mfp_ahb_default_slave
//   Answers transfers that decode to no slave with a two-cycle ERROR
//   response (ERR1: wait+ERROR, ERR2: ready+ERROR) and records the first
//   faulting address/direction for software.
// Ports:
//   clk_i, rst_i      bus clock, synchronous active-high reset
//   hready_i          bus HREADY (address phase accepted when high)
//   req_i             address phase is an unmapped NONSEQ/SEQ
//   haddr_i, hwrite_i address-phase address and direction
//   err_clr_i         clears err_valid_o (a coincident new fault wins)
//   hready_o, hresp_o data-phase response of the default slave
//   err_addr_o, err_write_o, err_valid_o  captured fault
module mfp_ahb_default_slave
  import mfp_ahb_interconnect_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hready_i,
  input  logic        req_i,
  input  logic [31:0] haddr_i,
  input  logic        hwrite_i,
  input  logic        err_clr_i,
  output logic        hready_o,
  output logic        hresp_o,
  output logic [31:0] err_addr_o,
  output logic        err_write_o,
  output logic        err_valid_o
);

  ds_state_e   state_q, state_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic        err_write_q, err_write_d;
  logic        err_valid_q, err_valid_d;
  logic        enter_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= DS_IDLE;
      err_addr_q  <= '0;
      err_write_q <= 1'b0;
      err_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_addr_q  <= err_addr_d;
      err_write_q <= err_write_d;
      err_valid_q <= err_valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hready_o = 1'b1;
    hresp_o  = 1'b0;
    case (state_q)
      DS_IDLE: if (hready_i && req_i) state_d = DS_ERR1;
      DS_ERR1: begin
        hready_o = 1'b0;
        hresp_o  = 1'b1;
        state_d  = DS_ERR2;
      end
      DS_ERR2: begin
        hresp_o = 1'b1;
        // Back-to-back faults chain straight into the next ERROR pair.
        state_d = (hready_i && req_i) ? DS_ERR1 : DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

  // Capture on entry to ERR1. A clear in the same cycle re-arms capture,
  // so the new fault is recorded and the flag stays set.
  assign enter_err = (state_d == DS_ERR1) && (state_q != DS_ERR1);

  always_comb begin
    err_addr_d  = err_addr_q;
    err_write_d = err_write_q;
    err_valid_d = err_valid_q;
    if (err_clr_i) err_valid_d = 1'b0;
    if (enter_err && (!err_valid_q || err_clr_i)) begin
      err_addr_d  = haddr_i;
      err_write_d = hwrite_i;
      err_valid_d = 1'b1;
    end
  end

  assign err_addr_o  = err_addr_q;
  assign err_write_o = err_write_q;
  assign err_valid_o = err_valid_q;

endmodule

// File: rtl/mfp_ahb_interconnect.sv
// mfp_ahb_interconnect
//   AHB-lite single-master interconnect: address decode to N_SLAVES
//   slaves (lowest index wins on overlap), registered data-phase select,
//   read-data/response return mux, and a built-in default slave that
//   errors unmapped transfers.
// Ports:
//   HCLK, HRESET                 clock, synchronous active-high reset
//   HADDR, HTRANS, HWRITE        master address phase
//   HRDATA, HREADY, HRESP        data-phase return to master (HREADY also
//                                feeds every slave's HREADY input)
//   HSEL                         one-hot address-phase slave select
//   S_HRDATA, S_HREADYOUT, S_HRESP  packed per-slave returns
//   ERR_ADDR, ERR_WRITE, ERR_VALID, ERR_CLR  unmapped-access capture
module mfp_ahb_interconnect
  import mfp_ahb_interconnect_pkg::*;
#(
  parameter int                      N_SLAVES = MFP_N_SLAVES_DEF,
  parameter logic [32*N_SLAVES-1:0]  SLV_BASE = (32*N_SLAVES)'(MFP_SLV_BASE_DEF),
  parameter logic [32*N_SLAVES-1:0]  SLV_MASK = (32*N_SLAVES)'(MFP_SLV_MASK_DEF)
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [31:0]              HADDR,
  input  logic [1:0]               HTRANS,
  input  logic                     HWRITE,
  output logic [31:0]              HRDATA,
  output logic                     HREADY,
  output logic                     HRESP,
  output logic [N_SLAVES-1:0]      HSEL,
  input  logic [32*N_SLAVES-1:0]   S_HRDATA,
  input  logic [N_SLAVES-1:0]      S_HREADYOUT,
  input  logic [N_SLAVES-1:0]      S_HRESP,
  output logic [31:0]              ERR_ADDR,
  output logic                     ERR_WRITE,
  output logic                     ERR_VALID,
  input  logic                     ERR_CLR
);

  logic [N_SLAVES-1:0] match;
  logic [N_SLAVES-1:0] hsel;
  logic                no_match;
  logic                xfer;

  // dsel bit N_SLAVES is the default slave.
  logic [N_SLAVES:0]   dsel_q, dsel_d;
  logic                dact_q, dact_d;

  logic [31:0]         mux_rdata;
  logic                mux_ready, mux_resp;
  logic                ds_hready, ds_hresp;

  // ---- address decode ------------------------------------------------
  for (genvar i = 0; i < N_SLAVES; i++) begin : g_dec
    assign match[i] = (HADDR & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32];
  end

  always_comb begin
    logic found;
    hsel  = '0;
    found = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (match[i] && !found) begin
        hsel[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  assign HSEL     = hsel;
  assign no_match = ~|match;
  assign xfer     = htrans_active(HTRANS);

  // ---- data-phase select ----------------------------------------------
  always_comb begin
    dsel_d = dsel_q;
    dact_d = dact_q;
    if (HREADY) begin
      dsel_d = {no_match, hsel};
      dact_d = xfer;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel_q <= '0;
      dact_q <= 1'b0;
    end else begin
      dsel_q <= dsel_d;
      dact_q <= dact_d;
    end
  end

  // ---- return mux (driven only by registered select, never by HADDR) --
  always_comb begin
    mux_rdata = '0;
    mux_ready = 1'b1;
    mux_resp  = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (dsel_q[i]) begin
        mux_rdata = S_HRDATA[32*i +: 32];
        mux_ready = S_HREADYOUT[i];
        mux_resp  = S_HRESP[i];
      end
    end
    if (dsel_q[N_SLAVES]) begin
      mux_ready = ds_hready;
      mux_resp  = ds_hresp;
    end
  end

  assign HRDATA = mux_rdata;
  assign HREADY = dact_q ? mux_ready : 1'b1;
  assign HRESP  = dact_q ? mux_resp  : 1'b0;

  // ---- default slave ---------------------------------------------------
  mfp_ahb_default_slave u_default_slave (
    .clk_i       (HCLK),
    .rst_i       (HRESET),
    .hready_i    (HREADY),
    .req_i       (no_match && xfer),
    .haddr_i     (HADDR),
    .hwrite_i    (HWRITE),
    .err_clr_i   (ERR_CLR),
    .hready_o    (ds_hready),
    .hresp_o     (ds_hresp),
    .err_addr_o  (ERR_ADDR),
    .err_write_o (ERR_WRITE),
    .err_valid_o (ERR_VALID)
  );

endmodule

// File: tb/tb_mfp_ahb_interconnect.sv
// Directed bench for mfp_ahb_interconnect with a three-slave map, plus a
// second instance whose slave1 mask is zero to exercise overlap priority.
module tb_mfp_ahb_interconnect;

  localparam int NS = 3;
  localparam logic [32*NS-1:0] TB_BASE = {32'h1F80_0000, 32'h0000_0000, 32'h1FC0_0000};
  localparam logic [32*NS-1:0] TB_MASK = {32'h1FC0_0000, 32'h1000_0000, 32'h1FC0_0000};
  localparam logic [32*NS-1:0] OV_MASK = {32'h1FC0_0000, 32'h0000_0000, 32'h1FC0_0000};

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10;

  logic            HCLK = 1'b0;
  logic            HRESET;
  logic [31:0]     HADDR;
  logic [1:0]      HTRANS;
  logic            HWRITE;
  logic [31:0]     HRDATA, ov_hrdata;
  logic            HREADY, HRESP, ov_hready, ov_hresp;
  logic [NS-1:0]   HSEL, ov_hsel;
  logic [32*NS-1:0] S_HRDATA;
  logic [NS-1:0]   S_HREADYOUT, S_HRESP;
  logic [31:0]     ERR_ADDR, ov_err_addr;
  logic            ERR_WRITE, ERR_VALID, ERR_CLR, ov_err_write, ov_err_valid;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 HCLK = ~HCLK;

  mfp_ahb_interconnect #(.N_SLAVES(NS), .SLV_BASE(TB_BASE), .SLV_MASK(TB_MASK)) u_dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .HSEL(HSEL),
    .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
    .ERR_ADDR(ERR_ADDR), .ERR_WRITE(ERR_WRITE), .ERR_VALID(ERR_VALID), .ERR_CLR(ERR_CLR)
  );

  mfp_ahb_interconnect #(.N_SLAVES(NS), .SLV_BASE(TB_BASE), .SLV_MASK(OV_MASK)) u_dut_ov (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HRDATA(ov_hrdata), .HREADY(ov_hready), .HRESP(ov_hresp), .HSEL(ov_hsel),
    .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
    .ERR_ADDR(ov_err_addr), .ERR_WRITE(ov_err_write), .ERR_VALID(ov_err_valid), .ERR_CLR(ERR_CLR)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Drive an address phase just after the clock edge, then move to the
  // falling edge where outputs are sampled.
  task automatic addr(input logic [31:0] a, input logic [1:0] t, input logic w);
    HADDR  = a;
    HTRANS = t;
    HWRITE = w;
  endtask

  task automatic to_neg();
    @(negedge HCLK);
  endtask

  task automatic to_pos();
    @(posedge HCLK);
    #1;
  endtask

  task automatic resp(input string tag, input logic rdy, input logic rsp);
    chk({tag, ".hready"}, {31'd0, HREADY}, {31'd0, rdy});
    chk({tag, ".hresp"},  {31'd0, HRESP},  {31'd0, rsp});
  endtask

  initial begin
    HRESET      = 1'b1;
    ERR_CLR     = 1'b0;
    S_HRDATA    = {32'hA5A5_0001, 32'h1111_1111, 32'h0000_0B00};
    S_HREADYOUT = '1;
    S_HRESP     = '0;
    addr(32'h0, T_IDLE, 1'b0);
    to_pos(); to_pos();
    HRESET = 1'b0;

    // ---- reset state
    to_neg();
    resp("rst", 1'b1, 1'b0);
    chk("rst.hrdata", HRDATA, 32'h0);
    chk("rst.err_valid", {31'd0, ERR_VALID}, 32'd0);
    chk("rst.err_addr", ERR_ADDR, 32'h0);
    to_pos();

    // ---- plain read from slave2
    addr(32'h1F80_0004, T_NSEQ, 1'b0);
    to_neg(); chk("rd2.hsel", {29'd0, HSEL}, 32'b100);
    to_pos();
    addr(32'h0, T_IDLE, 1'b0);
    to_neg();
    chk("rd2.hrdata", HRDATA, 32'hA5A5_0001);
    resp("rd2", 1'b1, 1'b0);
    to_pos();

    // ---- slave1 with 3 wait states; next address phase must wait
    addr(32'h0000_0010, T_NSEQ, 1'b0);
    to_neg(); chk("ws.hsel", {29'd0, HSEL}, 32'b010);
    to_pos();
    addr(32'h1F80_0004, T_NSEQ, 1'b0);
    S_HREADYOUT[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      to_neg();
      resp($sformatf("ws.wait%0d", c), 1'b0, 1'b0);
      to_pos();
    end
    S_HREADYOUT[1] = 1'b1;
    to_neg();
    chk("ws.hrdata", HRDATA, 32'h1111_1111);
    resp("ws.done", 1'b1, 1'b0);
    to_pos();
    addr(32'h0, T_IDLE, 1'b0);
    to_neg(); chk("ws.next_hrdata", HRDATA, 32'hA5A5_0001);
    to_pos();

    // ---- slave ERROR passes through
    addr(32'h1F80_0004, T_NSEQ, 1'b0);
    to_pos();
    addr(32'h0, T_IDLE, 1'b0);
    S_HRESP[2] = 1'b1;
    to_neg(); resp("slverr", 1'b1, 1'b1);
    to_pos();
    S_HRESP[2] = 1'b0;

    // ---- IDLE phase: slave outputs ignored
    addr(32'h0000_0010, T_IDLE, 1'b0);
    to_pos();
    S_HREADYOUT[1] = 1'b0;
    S_HRESP[1]     = 1'b1;
    to_neg(); resp("idle_ignore", 1'b1, 1'b0);
    to_pos();
    S_HREADYOUT[1] = 1'b1;
    S_HRESP[1]     = 1'b0;

    // ---- single unmapped write
    addr(32'h1F00_0000, T_NSEQ, 1'b1);
    to_neg(); chk("err.hsel", {29'd0, HSEL}, 32'b000);
    to_pos();
    addr(32'h0, T_IDLE, 1'b0);
    to_neg();
    resp("err.e1", 1'b0, 1'b1);
    chk("err.hrdata", HRDATA, 32'h0);
    chk("err.valid", {31'd0, ERR_VALID}, 32'd1);
    chk("err.addr", ERR_ADDR, 32'h1F00_0000);
    chk("err.write", {31'd0, ERR_WRITE}, 32'd1);
    to_pos();
    to_neg(); resp("err.e2", 1'b1, 1'b1);
    to_pos();
    to_neg(); resp("err.idle", 1'b1, 1'b0);
    to_pos();

    // ---- back-to-back unmapped, first error wins
    addr(32'h1F00_0000, T_NSEQ, 1'b0);
    to_pos();
    addr(32'h1F10_0000, T_NSEQ, 1'b0);
    to_neg(); resp("b2b.a1", 1'b0, 1'b1);
    to_pos();
    to_neg(); resp("b2b.a2", 1'b1, 1'b1);
    to_pos();
    to_neg();
    resp("b2b.b1", 1'b0, 1'b1);
    chk("b2b.addr", ERR_ADDR, 32'h1F00_0000);
    to_pos();
    // clear coincident with a third fault: set wins and it is captured
    addr(32'h1F20_0000, T_NSEQ, 1'b1);
    ERR_CLR = 1'b1;
    to_neg(); resp("b2b.b2", 1'b1, 1'b1);
    to_pos();
    ERR_CLR = 1'b0;
    addr(32'h0, T_IDLE, 1'b0);
    to_neg();
    resp("clr.c1", 1'b0, 1'b1);
    chk("clr.valid", {31'd0, ERR_VALID}, 32'd1);
    chk("clr.addr", ERR_ADDR, 32'h1F20_0000);
    chk("clr.write", {31'd0, ERR_WRITE}, 32'd1);
    to_pos();
    to_neg(); resp("clr.c2", 1'b1, 1'b1);
    to_pos();
    // plain clear keeps the captured address
    ERR_CLR = 1'b1;
    to_pos();
    ERR_CLR = 1'b0;
    to_neg();
    chk("clr2.valid", {31'd0, ERR_VALID}, 32'd0);
    chk("clr2.addr", ERR_ADDR, 32'h1F20_0000);
    to_pos();

    // ---- IDLE / BUSY to unmapped: OKAY, no capture
    addr(32'h1F00_0000, T_IDLE, 1'b0);
    to_pos();
    addr(32'h1F00_0000, T_BUSY, 1'b0);
    to_neg();
    resp("idle_unmap", 1'b1, 1'b0);
    chk("idle_unmap.valid", {31'd0, ERR_VALID}, 32'd0);
    to_pos();
    addr(32'h0, T_IDLE, 1'b0);
    to_neg();
    resp("busy_unmap", 1'b1, 1'b0);
    chk("busy_unmap.valid", {31'd0, ERR_VALID}, 32'd0);
    to_pos();

    // ---- overlap priority (slave1 mask 0 matches everything)
    addr(32'h1FC0_0000, T_NSEQ, 1'b0);
    to_neg();
    chk("ov.hsel_boot", {29'd0, ov_hsel}, 32'b001);
    chk("ov.main_hsel", {29'd0, HSEL}, 32'b001);
    addr(32'h1F00_0000, T_IDLE, 1'b0);
    #1 chk("ov.hsel_catch", {29'd0, ov_hsel}, 32'b010);
    to_pos();
    addr(32'h0, T_IDLE, 1'b0);
    to_pos();

    // ---- reset during ERR1
    addr(32'h1F00_0000, T_NSEQ, 1'b0);
    to_pos();
    addr(32'h0, T_IDLE, 1'b0);
    HRESET = 1'b1;
    to_neg(); resp("rst_err.e1", 1'b0, 1'b1);
    to_pos();
    HRESET = 1'b0;
    to_neg();
    resp("rst_err.after", 1'b1, 1'b0);
    chk("rst_err.valid", {31'd0, ERR_VALID}, 32'd0);
    chk("rst_err.addr", ERR_ADDR, 32'h0);
    chk("rst_err.hrdata", HRDATA, 32'h0);
    to_pos();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
